// File: rtl/datamemory_ws.sv
// datamemory_ws: byte-addressable MIPS data memory with req/ready handshake, wait states and big-endian byte/half/word lanes.
// Optional DMEM_ALIGN_CHK_EN adds err and rejects misaligned accesses instead of forcing alignment.
module datamemory_ws #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              WR_RD,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W+1:0] ADDR,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
`ifdef DMEM_ALIGN_CHK_EN
  output logic              err,
`endif
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [ADDR_W+1:0] a_q;
  logic [DATA_W-1:0] d_q, word, wmask, wdata, ld;
  logic [1:0] sz_q;
  logic rd_q, sx_q, ok;
  logic [4:0] bsh, hsh;
  logic [7:0] b;
  logic [15:0] h;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // offset 0 is the most significant lane, so shifts are taken from the inverted offset
  always_comb begin
    word  = mem[a_q[ADDR_W+1:2]];
    bsh   = {~a_q[1:0], 3'b000};
    hsh   = {~a_q[1], 4'b0000};
    b     = 8'(word >> bsh);
    h     = 16'(word >> hsh);
    wmask = sz_q[1] ? '1 : sz_q[0] ? 32'h0000_FFFF << hsh : 32'h0000_00FF << bsh;
    wdata = sz_q[1] ? d_q : sz_q[0] ? d_q << hsh : d_q << bsh;
    ld    = sz_q[1] ? word : sz_q[0] ? {{16{sx_q & h[15]}}, h} : {{24{sx_q & b[7]}}, b};
  end
`ifdef DMEM_ALIGN_CHK_EN
  assign ok = ~(sz_q == 2'b01 ? a_q[0] : sz_q[1] & |a_q[1:0]);
`else
  assign ok = 1'b1;
`endif
  always_ff @(posedge clk)
    if (state == ACCESS && !rd_q && ok) mem[a_q[ADDR_W+1:2]] <= (word & ~wmask) | (wdata & wmask);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      sz_q     <= '0;
      rd_q     <= 1'b0;
      sx_q     <= 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
      err      <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: if (req) begin
          a_q   <= ADDR;
          d_q   <= data_in;
          sz_q  <= size;
          rd_q  <= WR_RD;
          sx_q  <= sign_ext;
          cnt   <= 4'(WAIT_CYC);
          busy  <= 1'b1;
          state <= WAIT_CYC == 0 ? ACCESS : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (rd_q || !ok) data_out <= ok ? ld : '0;
`ifdef DMEM_ALIGN_CHK_EN
          err   <= ~ok;
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_datamemory_ws.sv
// tb_datamemory_ws: table-driven scoreboard bench for datamemory_ws with WAIT_CYC=2.
module tb_datamemory_ws;
  localparam int WC = 2;
  logic clk = 0, rst = 0, req = 0, WR_RD = 0, sign_ext = 0;
  logic [1:0] size = 0;
  logic [11:0] ADDR = 0;
  logic [31:0] data_in = 0, data_out;
  logic ready, busy, err;
  int n_run = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  typedef struct {logic rd; logic [1:0] sz; logic sx; logic [11:0] a; logic [31:0] d; logic [31:0] exp;} vec_t;
  vec_t tv[13];

  datamemory_ws #(.DATA_W(32), .ADDR_W(10), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .WR_RD(WR_RD), .size(size), .sign_ext(sign_ext),
    .ADDR(ADDR), .data_in(data_in), .data_out(data_out), .ready(ready),
`ifdef DMEM_ALIGN_CHK_EN
    .err(err),
`endif
    .busy(busy));

`ifndef DMEM_ALIGN_CHK_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // drives in the current cycle (ready cycle of the previous access, so back-to-back is exercised)
  task automatic access(input logic rd, input logic [1:0] sz, input logic sx, input logic [11:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input logic exp_err);
    int e;
    req = 1; WR_RD = rd; size = sz; sign_ext = sx; ADDR = a; data_in = d;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    req = 0; WR_RD = ~rd; size = 2'b00; ADDR = 12'hFFF; data_in = 32'h0;
    check($sformatf("busy_acc@%03h", a), {31'b0, busy}, 1);
    e = 0;
    while (!ready && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    check($sformatf("latency@%03h", a), e, WC + 1);
    check($sformatf("busy_done@%03h", a), {31'b0, busy}, 0);
    check($sformatf("data_out@%03h", a), data_out, exp_q.pop_front());
`ifdef DMEM_ALIGN_CHK_EN
    check($sformatf("err@%03h", a), {31'b0, err}, {31'b0, exp_err});
`endif
  endtask

  initial begin
    int bad;
    tv[0]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000};
    tv[1]  = '{1'b1, 2'b10, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
    tv[2]  = '{1'b0, 2'b00, 1'b0, 12'h011, 32'h0000005A, 32'hDEADBEEF};
    tv[3]  = '{1'b1, 2'b10, 1'b0, 12'h010, 32'h0,        32'hDE5ABEEF};
    tv[4]  = '{1'b1, 2'b00, 1'b1, 12'h010, 32'h0,        32'hFFFFFFDE};
    tv[5]  = '{1'b1, 2'b00, 1'b0, 12'h010, 32'h0,        32'h000000DE};
    tv[6]  = '{1'b1, 2'b01, 1'b1, 12'h012, 32'h0,        32'hFFFFBEEF};
    tv[7]  = '{1'b1, 2'b01, 1'b0, 12'h012, 32'h0,        32'h0000BEEF};
    tv[8]  = '{1'b1, 2'b00, 1'b1, 12'h013, 32'h0,        32'hFFFFFFEF};
    tv[9]  = '{1'b1, 2'b01, 1'b1, 12'h010, 32'h0,        32'hFFFFDE5A};
    tv[10] = '{1'b1, 2'b11, 1'b1, 12'h010, 32'h0,        32'hDE5ABEEF};
    tv[11] = '{1'b0, 2'b10, 1'b0, 12'h020, 32'hCAFEF00D, 32'hDE5ABEEF};
    tv[12] = '{1'b1, 2'b00, 1'b0, 12'h011, 32'h0,        32'h0000005A};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    rst = 1;
    for (int i = 0; i < 13; i++)
      access(tv[i].rd, tv[i].sz, tv[i].sx, tv[i].a, tv[i].d, tv[i].exp, 1'b0);
    // reset during WAIT aborts the store
    req = 1; WR_RD = 0; size = 2'b10; ADDR = 12'h020; data_in = 32'h12345678;
    @(posedge clk); #1;
    req = 0;
    @(posedge clk); #1;
    rst = 0; #1;
    check("abort_data_out", data_out, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_err", {31'b0, err}, 0);
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) bad++;
    end
    check("abort_no_ready", bad, 0);
    @(negedge clk);
    rst = 1;
    access(1'b1, 2'b10, 1'b0, 12'h020, 32'h0, 32'hCAFEF00D, 1'b0);
`ifdef DMEM_ALIGN_CHK_EN
    access(1'b0, 2'b10, 1'b0, 12'h013, 32'h11223344, 32'h00000000, 1'b1);
    access(1'b1, 2'b10, 1'b0, 12'h010, 32'h0, 32'hDE5ABEEF, 1'b0);
    access(1'b1, 2'b01, 1'b0, 12'h011, 32'h0, 32'h00000000, 1'b1);
`else
    access(1'b0, 2'b10, 1'b0, 12'h013, 32'h11223344, 32'hCAFEF00D, 1'b0);
    access(1'b1, 2'b10, 1'b0, 12'h010, 32'h0, 32'h11223344, 1'b0);
    access(1'b1, 2'b01, 1'b0, 12'h011, 32'h0, 32'h00001122, 1'b0);
`endif
    @(posedge clk); #1;
    check("ready_one_cycle", {31'b0, ready}, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/datamemory_ws.md
Name: datamemory_ws

Overview:
Parametrised, byte-addressable data memory for the MIPS datapath, the successor of the fixed 1K-word memory. Adds:
- a request/ready handshake;
- a configurable number of wait states;
- byte, halfword and word access with big-endian lane selection;
- sign/zero extension on loads.
It sits between the MEM stage and the memory array, and the stage stalls while busy=1.

Parameters:
DATA_W, 32, word width in bits; fixed at 32 because the byte-lane logic assumes 4 lanes.
ADDR_W, 10, word-address bits; depth = 2^ADDR_W words, byte address is ADDR_W+2 bits.
WAIT_CYC, 1, extra wait cycles per access; legal range 0..15.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
req  in  1  access request, sampled only in IDLE
WR_RD  in  1  1 = read (load), 0 = write (store)
size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
ADDR  in  ADDR_W+2  byte address
data_in  in  DATA_W  store data, right-justified for byte/half
data_out  out  DATA_W  load result, registered
ready  out  1  one-cycle completion pulse
busy  out  1  high from request acceptance until completion
err  out  1  misalignment flag; present only with DMEM_ALIGN_CHK_EN

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, data_out=0, ready=0, busy=0, err=0. The array is not cleared; contents are undefined at power-up and unaffected by reset.
- FSM states are IDLE, WAIT and ACCESS.
- IDLE, req=1 at edge N: latch ADDR, data_in, size, WR_RD and sign_ext. Load counter=WAIT_CYC and set busy=1. Go to WAIT, or straight to ACCESS if WAIT_CYC=0.
- WAIT: decrement the counter every edge; go to ACCESS on the edge where the counter is 1.
- ACCESS (one cycle): on its exit edge, perform the array write or read, register data_out, set ready=1 and busy=0, and go to IDLE.
- Latency: ready is high during the cycle after edge N+1+WAIT_CYC, for exactly one cycle. ready is cleared on the next edge.
- Back-to-back: a req seen in the cycle where ready=1 is accepted. Throughput is one access per WAIT_CYC+2 cycles.
- req while busy=1 is ignored, not queued. Inputs other than req are don't-care after latching.
- data_out holds its value until the next completed read. Writes leave data_out unchanged.
- Lanes (big-endian): byte offset 0 maps to bits 31:24 and offset 3 to bits 7:0. Half offset 0 maps to 31:16 and offset 2 to 15:0.
- Store: data_in[7:0] or data_in[15:0] is written into the selected lane; unselected lanes keep their value. A word store writes all 32 bits.
- Load: the selected byte/half is right-justified in data_out. Upper bits are copies of the lane MSB if sign_ext=1, else 0. sign_ext is ignored for word loads.
- Reset mid-operation: the access is aborted and ready is not pulsed. The array is written only on the ACCESS exit edge, so an aborted write leaves memory unchanged.
- There is no out-of-range case, because the address width exactly spans the depth.

Optional Feature:
Macro DMEM_ALIGN_CHK_EN.
- Defined:
  - Port err exists.
  - A halfword access with ADDR[0]=1, or a word access with ADDR[1:0]≠00, still completes with normal timing.
  - On completion, ready=1 and err=1 in the same cycle. No array write occurs, and data_out is forced to 0.
  - err is cleared with ready.
- Undefined:
  - Port err is absent.
  - Misaligned low address bits are forced to alignment: half ignores ADDR[0], word ignores ADDR[1:0]. The access proceeds normally.

Test Plan:
1. Hold rst=0 for 2 cycles, then release -> data_out=0, ready=0, busy=0. A req in the first cycle after release is accepted.
2. WAIT_CYC=2: word store 0xDEADBEEF to ADDR 0x010 at edge N -> busy=1 from N, ready high only after edge N+3. A following word load from 0x010 returns 0xDEADBEEF.
3. Byte store data_in=0x0000005A to ADDR 0x011, then word load from 0x010 -> 0xDE5ABEEF. The other lanes are unchanged.
4. Loads from that word:
   - byte 0x010, sign_ext=1 -> 0xFFFFFFDE;
   - byte 0x010, sign_ext=0 -> 0x000000DE;
   - half 0x012, sign_ext=1 -> 0xFFFFBEEF;
   - half 0x012, sign_ext=0 -> 0x0000BEEF.
5. Word store 0x12345678 to 0x020 (holding 0xCAFEF00D); pull rst low during WAIT -> no ready pulse, all outputs 0. A subsequent word load from 0x020 returns 0xCAFEF00D.
6. Word store 0x11223344 to ADDR 0x013:
   - with DMEM_ALIGN_CHK_EN -> ready=err=1, data_out=0, word 0x010 is unchanged;
   - without it -> a word load from 0x010 returns 0x11223344.
